// File: rtl/irq_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// irq_arbiter_pkg
// Shared types and constants for the N-source interrupt controller:
//   state_t     acknowledge state machine encoding (IDLE, ACK, WAIT)
//   MAX_IRQ     largest supported source count
//   IDX_W       width of a source index (covers MAX_IRQ sources)
//   DEF_IF_ADDR default IF register address
//   DEF_IE_ADDR default IE register address
//   NO_VECTOR   vector byte returned for a spurious acknowledge
//   vector_of() vector byte for a given source index
// ----------------------------------------------------------------------------
package irq_arbiter_pkg;

  localparam int          MAX_IRQ     = 8;
  localparam int          IDX_W       = 3;
  localparam logic [15:0] DEF_IF_ADDR = 16'hFF0F;
  localparam logic [15:0] DEF_IE_ADDR = 16'hFFFF;
  localparam logic [7:0]  NO_VECTOR   = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // base + idx*stride, deliberately truncated to 8 bits so the vector wraps.
  function automatic logic [7:0] vector_of(input logic [7:0]       base,
                                           input logic [7:0]       stride,
                                           input logic [IDX_W-1:0] idx);
    return base + 8'(idx) * stride;
  endfunction

endpackage

// File: rtl/irq_arbiter_if.sv
// ----------------------------------------------------------------------------
// irq_arbiter_if
// CPU I/O bus and interrupt signals between the CPU side and the controller.
//   cs, A, Di, rd_n, wr_n   register access (from memory controller / CPU)
//   Do                      register read data
//   m1_n, iorq_n            CPU cycle qualifiers (both low = acknowledge)
//   int_req                 source request lines
//   int_ack                 one-clock acknowledge pulse per source
//   int_n                   CPU interrupt line, active low
//   jump_addr               vector byte for the acknowledge cycle
// Modports: master = CPU/system side, slave = interrupt controller.
// ----------------------------------------------------------------------------
interface irq_arbiter_if #(
  parameter int NUM_IRQ = 5
) ();

  logic               cs;
  logic [15:0]        A;
  logic [7:0]         Di;
  logic [7:0]         Do;
  logic               rd_n;
  logic               wr_n;
  logic               m1_n;
  logic               iorq_n;
  logic [NUM_IRQ-1:0] int_req;
  logic [NUM_IRQ-1:0] int_ack;
  logic               int_n;
  logic [7:0]         jump_addr;

  modport master (
    output cs, A, Di, rd_n, wr_n, m1_n, iorq_n, int_req,
    input  Do, int_ack, int_n, jump_addr
  );

  modport slave (
    input  cs, A, Di, rd_n, wr_n, m1_n, iorq_n, int_req,
    output Do, int_ack, int_n, jump_addr
  );

endinterface

// File: rtl/irq_priority_enc.sv
// ----------------------------------------------------------------------------
// irq_priority_enc
// Fixed-priority encoder: reports the lowest-index set bit of req.
//   req    in  WIDTH  request vector
//   valid  out 1      any bit of req set
//   index  out IDX_W  index of the lowest set bit (0 when none)
// ----------------------------------------------------------------------------
module irq_priority_enc
  import irq_arbiter_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = |req;
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// ----------------------------------------------------------------------------
// irq_arbiter
// Parametrised N-source interrupt controller. Holds IF (request flags) and
// IE (enables) on the CPU I/O bus, drives int_n, and answers the CPU
// interrupt-acknowledge cycle with a vector byte and a per-source int_ack.
//
// Ports:
//   clock  in  system clock
//   reset  in  synchronous, active-high reset
//   bus    irq_arbiter_if.slave (cs, A, Di, Do, rd_n, wr_n, m1_n, iorq_n,
//          int_req, int_ack, int_n, jump_addr)
//
// Build option:
//   IRQ_ARBITER_EDGE_DETECT_EN  defined: IF[i] set on a 0->1 edge of
//                               int_req[i]; undefined: IF[i] set every clock
//                               int_req[i] is high (level-sensitive).
// ----------------------------------------------------------------------------
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int          NUM_IRQ       = 5,
  parameter logic [7:0]  VECTOR_BASE   = 8'h40,
  parameter logic [7:0]  VECTOR_STRIDE = 8'd8,
  parameter logic [15:0] IF_ADDR       = DEF_IF_ADDR,
  parameter logic [15:0] IE_ADDR       = DEF_IE_ADDR
) (
  input  logic         clock,
  input  logic         reset,
  irq_arbiter_if.slave bus
);

  logic [NUM_IRQ-1:0] if_q;
  logic [NUM_IRQ-1:0] ie_q;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] req_set;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [NUM_IRQ-1:0] if_next;
  logic [NUM_IRQ-1:0] int_ack_q;
  logic               wr_n_q;
  logic               wr_stb;
  logic               wr_if;
  logic               wr_ie;
  logic               ack_bus;
  logic               enc_valid;
  logic [IDX_W-1:0]   enc_index;
  logic               valid_q;
  logic [IDX_W-1:0]   sel_q;
  logic               int_n_q;
  logic [7:0]         jump_q;
  logic [7:0]         do_v;
  state_t             state;

  function automatic logic [NUM_IRQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_IRQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (IDX_W'(i) == idx) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign pending = if_q & ie_q;
  assign ack_bus = !bus.iorq_n && !bus.m1_n;

  irq_priority_enc #(
    .WIDTH (NUM_IRQ)
  ) u_enc (
    .req   (pending),
    .valid (enc_valid),
    .index (enc_index)
  );

  // A held wr_n low writes only once: qualify with the previous wr_n level.
  assign wr_stb = bus.cs && !bus.wr_n && wr_n_q;
  assign wr_if  = wr_stb && (bus.A == IF_ADDR);
  assign wr_ie  = wr_stb && (bus.A == IE_ADDR);

`ifdef IRQ_ARBITER_EDGE_DETECT_EN
  logic [NUM_IRQ-1:0] req_prev;

  assign req_set = bus.int_req & ~req_prev;

  always_ff @(posedge clock) begin
    if (reset) req_prev <= '0;
    else       req_prev <= bus.int_req;
  end
`else
  assign req_set = bus.int_req;
`endif

  // Service clear lands at the end of the ACK clock.
  assign ack_clr = (state == ACK && valid_q) ? onehot(sel_q) : '0;

  // Request sets are applied last so they beat a same-clock written clear.
  assign if_next = ((wr_if ? bus.Di[NUM_IRQ-1:0] : if_q) & ~ack_clr) | req_set;

  always_ff @(posedge clock) begin
    if (reset) begin
      if_q      <= '0;
      ie_q      <= '0;
      wr_n_q    <= 1'b1;
      int_n_q   <= 1'b1;
      int_ack_q <= '0;
      jump_q    <= NO_VECTOR;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      state     <= IDLE;
    end else begin
      if_q      <= if_next;
      wr_n_q    <= bus.wr_n;
      int_n_q   <= ~(|pending);
      int_ack_q <= '0;
      if (wr_ie) ie_q <= bus.Di[NUM_IRQ-1:0];

      unique case (state)
        IDLE: begin
          if (ack_bus) begin
            state     <= ACK;
            sel_q     <= enc_index;
            valid_q   <= enc_valid;
            jump_q    <= enc_valid ? vector_of(VECTOR_BASE, VECTOR_STRIDE, enc_index)
                                   : NO_VECTOR;
            int_ack_q <= enc_valid ? onehot(enc_index) : '0;
          end
        end
        // Always one clock in ACK, even if the bus already released.
        ACK: state <= WAIT;
        WAIT: begin
          if (!ack_bus) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset asserted during ACK suppresses the pulse that is already on its way.
  assign bus.int_ack   = int_ack_q & ~{NUM_IRQ{reset}};
  assign bus.int_n     = int_n_q;
  assign bus.jump_addr = jump_q;

  // Reads: register in the low bits, unused upper bits read as ones.
  always_comb begin
    do_v = 8'hFF;
    if (bus.cs && !bus.rd_n) begin
      if (bus.A == IF_ADDR) begin
        for (int i = 0; i < NUM_IRQ; i++) do_v[i] = if_q[i];
      end else if (bus.A == IE_ADDR) begin
        for (int i = 0; i < NUM_IRQ; i++) do_v[i] = ie_q[i];
      end
    end
  end

  assign bus.Do = do_v;

endmodule

// File: tb/tb_irq_arbiter.sv
// ----------------------------------------------------------------------------
// tb_irq_arbiter
// Directed bench for irq_arbiter: a register-access vector table followed by
// hand-written sequences for service, priority, spurious acknowledge, write
// versus request, reset during acknowledge and an 8-source wrap instance.
// ----------------------------------------------------------------------------
module tb_irq_arbiter;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  irq_arbiter_if #(.NUM_IRQ(5)) bus5 ();
  irq_arbiter_if #(.NUM_IRQ(8)) bus8 ();

  irq_arbiter #(
    .NUM_IRQ (5)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus5)
  );

  irq_arbiter #(
    .NUM_IRQ       (8),
    .VECTOR_BASE   (8'hF8),
    .VECTOR_STRIDE (8'd8)
  ) u_dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (bus8)
  );

  localparam logic [15:0] IFA = 16'hFF0F;
  localparam logic [15:0] IEA = 16'hFFFF;

  typedef struct {
    logic        do_wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_do;
    logic        exp_int_n;
  } vec_t;

  vec_t vecs[8];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", name, got, exp);
  endtask

  task automatic wr5(input logic [15:0] addr, input logic [7:0] data);
    bus5.A    = addr;
    bus5.Di   = data;
    bus5.cs   = 1'b1;
    bus5.wr_n = 1'b0;
    tick();
    bus5.wr_n = 1'b1;
    bus5.cs   = 1'b0;
    tick();
  endtask

  task automatic rd5(input logic [15:0] addr, output logic [7:0] d);
    bus5.A    = addr;
    bus5.cs   = 1'b1;
    bus5.rd_n = 1'b0;
    #1;
    d         = bus5.Do;
    bus5.cs   = 1'b0;
    bus5.rd_n = 1'b1;
  endtask

  task automatic ack5(input string name, input logic [7:0] exp_jump, input logic [7:0] exp_ack);
    bus5.iorq_n = 1'b0;
    bus5.m1_n   = 1'b0;
    tick();
    check({name, "_jump"}, bus5.jump_addr, exp_jump);
    check({name, "_ack"}, 8'(bus5.int_ack), exp_ack);
    bus5.iorq_n = 1'b1;
    bus5.m1_n   = 1'b1;
    tick();
    check({name, "_ack_end"}, 8'(bus5.int_ack), 8'h00);
    tick();
  endtask

  logic [7:0] d;

  initial begin
    vecs[0] = '{1'b1, IEA, 8'h00, 8'hE0, 1'b1};
    vecs[1] = '{1'b1, IFA, 8'h0A, 8'hEA, 1'b1};
    vecs[2] = '{1'b1, IEA, 8'h08, 8'hE8, 1'b0};
    vecs[3] = '{1'b1, IEA, 8'hF4, 8'hF4, 1'b1};
    vecs[4] = '{1'b1, IFA, 8'hFF, 8'hFF, 1'b0};
    vecs[5] = '{1'b1, IFA, 8'h00, 8'hE0, 1'b1};
    vecs[6] = '{1'b1, IEA, 8'h00, 8'hE0, 1'b1};
    vecs[7] = '{1'b0, 16'hFF0E, 8'h00, 8'hFF, 1'b1};

    bus5.cs = 1'b0; bus5.A = '0; bus5.Di = '0; bus5.rd_n = 1'b1; bus5.wr_n = 1'b1;
    bus5.m1_n = 1'b1; bus5.iorq_n = 1'b1; bus5.int_req = '0;
    bus8.cs = 1'b0; bus8.A = '0; bus8.Di = '0; bus8.rd_n = 1'b1; bus8.wr_n = 1'b1;
    bus8.m1_n = 1'b1; bus8.iorq_n = 1'b1; bus8.int_req = '0;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_int_n", 8'(bus5.int_n), 8'h01);
    check("rst_int_ack", 8'(bus5.int_ack), 8'h00);
    check("rst_jump", bus5.jump_addr, 8'hFF);
    rd5(IFA, d); check("rst_if", d, 8'hE0);
    rd5(IEA, d); check("rst_ie", d, 8'hE0);
    reset = 1'b0;
    tick();

    // Register access table
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_wr) wr5(vecs[i].addr, vecs[i].wdata);
      tick();
      rd5(vecs[i].addr, d);
      check($sformatf("vec%0d_do", i), d, vecs[i].exp_do);
      check($sformatf("vec%0d_int_n", i), 8'(bus5.int_n), 8'(vecs[i].exp_int_n));
    end

    // Basic service of source 2
    wr5(IEA, 8'h1F);
    bus5.int_req = 5'b00100;
    tick();
    bus5.int_req = '0;
    check("svc_int_n_1clk", 8'(bus5.int_n), 8'h01);
    rd5(IFA, d); check("svc_if_set", d, 8'hE4);
    tick();
    check("svc_int_n_2clk", 8'(bus5.int_n), 8'h00);
    ack5("svc", 8'h50, 8'h04);
    check("svc_int_n_after", 8'(bus5.int_n), 8'h01);
    check("svc_jump_hold", bus5.jump_addr, 8'h50);
    rd5(IFA, d); check("svc_if_clr", d, 8'hE0);

    // Priority: sources 4 and 1 together
    bus5.int_req = 5'b10010;
    tick();
    bus5.int_req = '0;
    tick();
    ack5("pri1", 8'h48, 8'h02);
    rd5(IFA, d); check("pri_if_left", d, 8'hF0);
    check("pri_int_n_still", 8'(bus5.int_n), 8'h00);
    ack5("pri2", 8'h60, 8'h10);
    check("pri_int_n_done", 8'(bus5.int_n), 8'h01);

    // Masked request and spurious acknowledge
    wr5(IEA, 8'h00);
    bus5.int_req = 5'b00001;
    tick();
    bus5.int_req = '0;
    tick();
    tick();
    check("mask_int_n", 8'(bus5.int_n), 8'h01);
    rd5(IFA, d); check("mask_if", d, 8'hE1);
    ack5("spur", 8'hFF, 8'h00);
    rd5(IFA, d); check("spur_if_kept", d, 8'hE1);
    wr5(IFA, 8'h00);

    // Write clear and request edge in the same clock
    bus5.A = IFA; bus5.Di = 8'h00; bus5.cs = 1'b1; bus5.wr_n = 1'b0;
    bus5.int_req = 5'b01000;
    tick();
    bus5.int_req = '0;
    bus5.wr_n = 1'b1; bus5.cs = 1'b0;
    rd5(IFA, d); check("wvs_set_wins", d, 8'hE8);
    tick();

    // wr_n held low for 4 clocks writes once
    bus5.A = IFA; bus5.Di = 8'h00; bus5.cs = 1'b1; bus5.wr_n = 1'b0;
    tick();
    bus5.int_req = 5'b00010;
    tick();
    bus5.int_req = '0;
    tick();
    tick();
    bus5.wr_n = 1'b1; bus5.cs = 1'b0;
    rd5(IFA, d); check("wr_held_once", d, 8'hE2);
    wr5(IFA, 8'h00);

    // Clear written while a request is held high
    bus5.int_req = 5'b00001;
    tick();
    tick();
    bus5.A = IFA; bus5.Di = 8'h00; bus5.cs = 1'b1; bus5.wr_n = 1'b0;
    tick();
    bus5.wr_n = 1'b1; bus5.cs = 1'b0;
    tick();
    rd5(IFA, d);
`ifdef IRQ_ARBITER_EDGE_DETECT_EN
    check("held_req_once", d, 8'hE0);
`else
    check("held_req_level", d, 8'hE1);
`endif
    bus5.int_req = '0;
    tick();
    wr5(IFA, 8'h00);

    // Reset during ACK
    wr5(IEA, 8'h1F);
    bus5.int_req = 5'b00100;
    tick();
    bus5.int_req = '0;
    tick();
    bus5.iorq_n = 1'b0;
    bus5.m1_n   = 1'b0;
    tick();
    check("rack_jump", bus5.jump_addr, 8'h50);
    reset = 1'b1;
    #1;
    check("rack_no_pulse", 8'(bus5.int_ack), 8'h00);
    tick();
    bus5.iorq_n = 1'b1;
    bus5.m1_n   = 1'b1;
    check("rack_int_n", 8'(bus5.int_n), 8'h01);
    check("rack_int_ack", 8'(bus5.int_ack), 8'h00);
    check("rack_jump_rst", bus5.jump_addr, 8'hFF);
    rd5(IFA, d); check("rack_if", d, 8'hE0);
    rd5(IEA, d); check("rack_ie", d, 8'hE0);
    reset = 1'b0;
    tick();
    tick();
    check("rack_idle_ack", 8'(bus5.int_ack), 8'h00);

    // 8-source instance: full-width IF and vector wrap
    bus8.A = IEA; bus8.Di = 8'hFF; bus8.cs = 1'b1; bus8.wr_n = 1'b0;
    tick();
    bus8.wr_n = 1'b1; bus8.cs = 1'b0;
    tick();
    bus8.A = IFA; bus8.Di = 8'hA4; bus8.cs = 1'b1; bus8.wr_n = 1'b0;
    tick();
    bus8.wr_n = 1'b1; bus8.cs = 1'b0;
    tick();
    bus8.A = IFA; bus8.cs = 1'b1; bus8.rd_n = 1'b0;
    #1;
    check("w8_if_read", bus8.Do, 8'hA4);
    bus8.cs = 1'b0; bus8.rd_n = 1'b1;
    bus8.int_req = 8'h02;
    tick();
    bus8.int_req = '0;
    tick();
    check("w8_int_n", 8'(bus8.int_n), 8'h00);
    bus8.iorq_n = 1'b0;
    bus8.m1_n   = 1'b0;
    tick();
    check("w8_jump_wrap", bus8.jump_addr, 8'h00);
    check("w8_ack", bus8.int_ack, 8'h02);
    bus8.iorq_n = 1'b1;
    bus8.m1_n   = 1'b1;
    tick();
    tick();
    bus8.A = IFA; bus8.cs = 1'b1; bus8.rd_n = 1'b0;
    #1;
    check("w8_if_after", bus8.Do, 8'hA4);
    bus8.cs = 1'b0; bus8.rd_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
